// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write-port arbiter: pipeline WB over queued long-latency results
// Optional build macro: WB_ARB_PERF_EN adds stall and conflict performance counters.
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8,
    parameter int DATA_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wb_valid,
    input  logic [4:0]        i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_lu_valid,
    output logic              o_lu_ready,
    input  logic [4:0]        i_lu_rd,
    input  logic [DATA_W-1:0] i_lu_data,
    output logic              o_pipe_stall,
    output logic [31:0]       o_pending,
    output logic              o_rd_wren,
    output logic [4:0]        o_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_conflict_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [DEPTH-1:0]  q_vld;
    logic [4:0]        q_rd   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [WW-1:0]     wait_cnt;

    logic full;
    logic empty;
    logic pipe_req;
    logic push;
    logic pop;
    logic grant_pipe;
    logic force_drain;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign o_lu_ready  = !full;
    assign pipe_req    = i_wb_valid && (i_wb_rd != 5'd0);
    // rd=0 results finish the handshake but are dropped: x0 is never written.
    assign push        = i_lu_valid && !full && (i_lu_rd != 5'd0);
    assign force_drain = (wait_cnt == WW'(MAX_WAIT)) && !empty;
    assign o_pipe_stall = force_drain;

    // Single grant per cycle: starvation drain, then pipeline, then idle drain.
    always_comb begin
        grant_pipe = 1'b0;
        pop        = 1'b0;
        if (force_drain) begin
            pop = 1'b1;
        end else if (pipe_req) begin
            grant_pipe = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
        end
    end

    // FIFO pointers, occupancy and per-slot valid bits.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            q_vld <= '0;
        end else begin
            if (push) begin
                q_vld[tail] <= 1'b1;
                tail        <= tail + AW'(1);
            end
            if (pop) begin
                q_vld[head] <= 1'b0;
                head        <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO payload storage; contents are qualified by q_vld so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (push) begin
            q_rd[tail]   <= i_lu_rd;
            q_data[tail] <= i_lu_data;
        end
    end

    // Starvation counter: counts cycles a non-empty FIFO goes without draining.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wait_cnt <= '0;
        end else if (pop || empty) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WW'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Pending-destination mask for the hazard unit, from queued entries only.
    always_comb begin
        o_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i]) begin
                o_pending[q_rd[i]] = 1'b1;
            end
        end
        o_pending[0] = 1'b0;
    end

    // Registered regfile write port; address/data hold when no write is granted.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rd_wren <= 1'b0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
        end else if (grant_pipe) begin
            o_rd_wren <= 1'b1;
            o_rd_addr <= i_wb_rd;
            o_rd_data <= i_wb_data;
        end else if (pop) begin
            o_rd_wren <= 1'b1;
            o_rd_addr <= q_rd[head];
            o_rd_data <= q_data[head];
        end else begin
            o_rd_wren <= 1'b0;
        end
    end

`ifdef WB_ARB_PERF_EN
    // Performance counters: forced-stall cycles and pipe/queue contention cycles.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_stall_cnt    <= '0;
            o_conflict_cnt <= '0;
        end else begin
            if (o_pipe_stall) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
            if (pipe_req && !empty) begin
                o_conflict_cnt <= o_conflict_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        pipe_stall;
    logic [31:0] pending;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
`ifdef WB_ARB_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] conflict_cnt;
    logic [31:0] stall_base;
    logic [31:0] conflict_base;
`endif

    int n_checks;
    int n_errors;

    wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(8), .DATA_W(32)) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_wb_valid   (wb_valid),
        .i_wb_rd      (wb_rd),
        .i_wb_data    (wb_data),
        .i_lu_valid   (lu_valid),
        .o_lu_ready   (lu_ready),
        .i_lu_rd      (lu_rd),
        .i_lu_data    (lu_data),
        .o_pipe_stall (pipe_stall),
        .o_pending    (pending),
        .o_rd_wren    (rd_wren),
        .o_rd_addr    (rd_addr),
        .o_rd_data    (rd_data)
`ifdef WB_ARB_PERF_EN
        ,
        .o_stall_cnt    (stall_cnt),
        .o_conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lu_valid = v;
        lu_rd    = rd;
        lu_data  = d;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        set_lu(1'b0, 5'd0, 32'd0);
        step();
        step();

        // Reset state
        chk("rst_lu_ready", 32'(lu_ready), 32'd1);
        chk("rst_wren",     32'(rd_wren), 32'd0);
        chk("rst_addr",     32'(rd_addr), 32'd0);
        chk("rst_data",     rd_data, 32'd0);
        chk("rst_stall",    32'(pipe_stall), 32'd0);
        chk("rst_pending",  pending, 32'd0);
        rst_n = 1'b1;
        step();

        // Idle drain
        set_lu(1'b1, 5'd3, 32'hAAAA_0001);
        step();
        set_lu(1'b0, 5'd0, 32'd0);
        chk("s2_pending_set", pending, 32'h0000_0008);
        chk("s2_wren_0",      32'(rd_wren), 32'd0);
        step();
        chk("s2_wren",        32'(rd_wren), 32'd1);
        chk("s2_addr",        32'(rd_addr), 32'd3);
        chk("s2_data",        rd_data, 32'hAAAA_0001);
        chk("s2_pending_clr", pending, 32'd0);
        step();
        chk("s2_wren_off",    32'(rd_wren), 32'd0);

        // Priority and starvation stall
        set_wb(1'b1, 5'd9, 32'h11);
`ifdef WB_ARB_PERF_EN
        stall_base    = stall_cnt;
        conflict_base = conflict_cnt;
`endif
        set_lu(1'b1, 5'd4, 32'h44);
        step();
        set_lu(1'b0, 5'd0, 32'd0);
        chk("s3_stall_e0", 32'(pipe_stall), 32'd0);
        chk("s3_pend",     pending, 32'h0000_0010);
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("s3_stall_wait", 32'(pipe_stall), 32'd0);
            chk("s3_pipe_addr",  32'(rd_addr), 32'd9);
            chk("s3_pipe_wren",  32'(rd_wren), 32'd1);
        end
        step();
        chk("s3_stall_on",  32'(pipe_stall), 32'd1);
        chk("s3_addr_e8",   32'(rd_addr), 32'd9);
        step();
        chk("s3_stall_off", 32'(pipe_stall), 32'd0);
        chk("s3_lu_addr",   32'(rd_addr), 32'd4);
        chk("s3_lu_data",   rd_data, 32'h44);
        chk("s3_pend_clr",  pending, 32'd0);
        step();
        chk("s3_held_addr", 32'(rd_addr), 32'd9);
        chk("s3_held_data", rd_data, 32'h11);
        chk("s3_held_wren", 32'(rd_wren), 32'd1);
`ifdef WB_ARB_PERF_EN
        chk("s3_stall_cnt",    stall_cnt - stall_base, 32'd1);
        chk("s3_conflict_cnt", conflict_cnt - conflict_base, 32'd9);
`endif

        // Full FIFO under continuous pipeline writes
        for (int i = 0; i < 4; i++) begin
            chk("s4_ready_fill", 32'(lu_ready), 32'd1);
            set_lu(1'b1, 5'(10 + i), 32'(i + 100));
            step();
        end
        chk("s4_ready_full", 32'(lu_ready), 32'd0);
        chk("s4_pend_full",  pending, 32'h0000_3C00);
        set_lu(1'b1, 5'd20, 32'h20);
        step();
        chk("s4_no_5th",     pending, 32'h0000_3C00);
        chk("s4_ready_hold", 32'(lu_ready), 32'd0);
        set_lu(1'b0, 5'd0, 32'd0);
        set_wb(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s4_drain_addr", 32'(rd_addr), 32'(10 + i));
            chk("s4_drain_data", rd_data, 32'(i + 100));
        end
        step();
        chk("s4_wren_idle", 32'(rd_wren), 32'd0);
        chk("s4_ready_back", 32'(lu_ready), 32'd1);
        chk("s4_pend_empty", pending, 32'd0);

        // rd=0 handling
        set_wb(1'b1, 5'd0, 32'hDEAD);
        set_lu(1'b1, 5'd6, 32'h66);
        step();
        set_lu(1'b0, 5'd0, 32'd0);
        chk("s5_wren_none", 32'(rd_wren), 32'd0);
        chk("s5_pend6",     pending, 32'h0000_0040);
        step();
        chk("s5_pop_wren",  32'(rd_wren), 32'd1);
        chk("s5_pop_addr",  32'(rd_addr), 32'd6);
        chk("s5_pop_data",  rd_data, 32'h66);
        set_lu(1'b1, 5'd0, 32'h77);
        chk("s5_lu0_ready", 32'(lu_ready), 32'd1);
        step();
        set_lu(1'b0, 5'd0, 32'd0);
        chk("s5_lu0_pend",  pending, 32'd0);
        chk("s5_lu0_wren",  32'(rd_wren), 32'd0);
        step();
        chk("s5_lu0_never", 32'(rd_wren), 32'd0);
        set_wb(1'b0, 5'd0, 32'd0);

        // Simultaneous push/pop at count=2
        set_wb(1'b1, 5'd9, 32'h11);
        set_lu(1'b1, 5'd21, 32'h2100);
        step();
        set_lu(1'b1, 5'd22, 32'h2200);
        step();
        set_wb(1'b0, 5'd0, 32'd0);
        set_lu(1'b1, 5'd23, 32'h2300);
        chk("s6_pend_two", pending, 32'h0060_0000);
        step();
        set_lu(1'b0, 5'd0, 32'd0);
        chk("s6_pend_swap", pending, 32'h00C0_0000);
        chk("s6_addr0",     32'(rd_addr), 32'd21);
        chk("s6_data0",     rd_data, 32'h2100);
        step();
        chk("s6_addr1",     32'(rd_addr), 32'd22);
        chk("s6_data1",     rd_data, 32'h2200);
        step();
        chk("s6_addr2",     32'(rd_addr), 32'd23);
        chk("s6_data2",     rd_data, 32'h2300);
        step();
        chk("s6_idle",      32'(rd_wren), 32'd0);
        chk("s6_pend_end",  pending, 32'd0);

        // Reset mid-queue
        set_wb(1'b1, 5'd9, 32'h11);
        set_lu(1'b1, 5'd5, 32'h55);
        step();
        set_lu(1'b1, 5'd7, 32'h77);
        step();
        set_lu(1'b0, 5'd0, 32'd0);
        chk("s1_pend_pre", pending, 32'h0000_00A0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s1_pend_rst",  pending, 32'd0);
        chk("s1_wren_rst",  32'(rd_wren), 32'd0);
        chk("s1_ready_rst", 32'(lu_ready), 32'd1);
        chk("s1_stall_rst", 32'(pipe_stall), 32'd0);
        set_wb(1'b0, 5'd0, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s1_no_write", 32'(rd_wren), 32'd0);
        end
        chk("s1_pend_post", pending, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
